// File: rtl/xor_unit.sv
// xor_unit: registered a^b with zero/parity flags (ports clk, rst, in_valid, a, b -> out_valid, result, zero, parity, popcount when XOR_UNIT_POPCOUNT_EN)
module xor_unit #(
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic                     parity
`ifdef XOR_UNIT_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH):0]   popcount
`endif
);
  logic [WIDTH-1:0] x;
  assign x = a ^ b;
`ifdef XOR_UNIT_POPCOUNT_EN
  localparam int PW = $clog2(WIDTH) + 1;
  logic [PW-1:0] pc;
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + PW'(x[i]);
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
`ifdef XOR_UNIT_POPCOUNT_EN
      popcount  <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= x;
        zero   <= ~|x;
        parity <= ^x;
`ifdef XOR_UNIT_POPCOUNT_EN
        popcount <= pc;
`endif
      end
    end
  end
endmodule

// File: tb/tb_xor_unit.sv
// tb_xor_unit: randomized and directed checks of xor_unit against a behavioural model
module tb_xor_unit;
  localparam int W = 64;
  logic clk = 1'b0;
  logic rst, in_valid, out_valid, zero, parity;
  logic [W-1:0] a, b, result;
`ifdef XOR_UNIT_POPCOUNT_EN
  logic [6:0] popcount;
`endif
  int checks = 0;
  int errors = 0;
  logic m_valid, m_zero, m_parity;
  logic [W-1:0] m_result;
  int m_pc;
  always #5 clk = ~clk;
  xor_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .zero(zero), .parity(parity)
`ifdef XOR_UNIT_POPCOUNT_EN
    , .popcount(popcount)
`endif
  );
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    rst = r;
    in_valid = v;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0;
      m_result = '0;
      m_zero = 1'b0;
      m_parity = 1'b0;
      m_pc = 0;
    end else begin
      m_valid = v;
      if (v) begin
        m_result = x ^ y;
        m_zero = (m_result == 0);
        m_pc = $countones(m_result);
        m_parity = m_pc[0];
      end
    end
  endtask
  task automatic test_reset;
    cycle(1'b1, 1'b1, '1, '0);
    cycle(1'b1, 1'b1, '1, 64'h1234);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
    checks++; if (parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", parity); end
`ifdef XOR_UNIT_POPCOUNT_EN
    checks++; if (popcount !== 7'd0) begin errors++; $display("FAIL reset_popcount got %0d want 0", popcount); end
`endif
  endtask
  task automatic test_complementary;
    cycle(1'b0, 1'b1, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL comp_out_valid got %b want 1", out_valid); end
    checks++; if (result !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL comp_result got %h want ffffffffffffffff", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL comp_zero got %b want 0", zero); end
    checks++; if (parity !== 1'b0) begin errors++; $display("FAIL comp_parity got %b want 0", parity); end
`ifdef XOR_UNIT_POPCOUNT_EN
    checks++; if (popcount !== 7'd64) begin errors++; $display("FAIL comp_popcount got %0d want 64", popcount); end
`endif
  endtask
  task automatic test_identical;
    cycle(1'b0, 1'b1, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ident_out_valid got %b want 1", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL ident_result got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL ident_zero got %b want 1", zero); end
    checks++; if (parity !== 1'b0) begin errors++; $display("FAIL ident_parity got %b want 0", parity); end
`ifdef XOR_UNIT_POPCOUNT_EN
    checks++; if (popcount !== 7'd0) begin errors++; $display("FAIL ident_popcount got %0d want 0", popcount); end
`endif
  endtask
  task automatic test_single_bit_hold;
    cycle(1'b0, 1'b1, 64'h1, 64'h0);
    checks++; if (result !== 64'h1) begin errors++; $display("FAIL single_result got %h want 1", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL single_zero got %b want 0", zero); end
    checks++; if (parity !== 1'b1) begin errors++; $display("FAIL single_parity got %b want 1", parity); end
`ifdef XOR_UNIT_POPCOUNT_EN
    checks++; if (popcount !== 7'd1) begin errors++; $display("FAIL single_popcount got %0d want 1", popcount); end
`endif
    cycle(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 64'h1) begin errors++; $display("FAIL hold_result got %h want 1", result); end
    checks++; if (parity !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL hold_flags got parity=%b zero=%b want parity=1 zero=0", parity, zero); end
  endtask
  task automatic test_back_to_back;
    cycle(1'b0, 1'b1, 64'hF0, 64'h0F);
    checks++; if (out_valid !== 1'b1 || result !== 64'hFF) begin errors++; $display("FAIL b2b_first got valid=%b result=%h want valid=1 result=ff", out_valid, result); end
    cycle(1'b0, 1'b1, 64'hFF, 64'hFF);
    checks++; if (out_valid !== 1'b1 || result !== 64'h0) begin errors++; $display("FAIL b2b_second got valid=%b result=%h want valid=1 result=0", out_valid, result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL b2b_zero got %b want 1", zero); end
  endtask
  task automatic test_reset_during_op;
    cycle(1'b0, 1'b1, 64'h5, 64'h0);
    cycle(1'b1, 1'b1, '1, '0);
    checks++; if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b0 || parity !== 1'b0) begin errors++; $display("FAIL rst_op_outputs got valid=%b result=%h zero=%b parity=%b want all 0", out_valid, result, zero, parity); end
    cycle(1'b0, 1'b1, 64'h3, 64'h1);
    checks++; if (out_valid !== 1'b1 || result !== 64'h2) begin errors++; $display("FAIL rst_op_resume got valid=%b result=%h want valid=1 result=2", out_valid, result); end
    checks++; if (parity !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL rst_op_flags got parity=%b zero=%b want parity=1 zero=0", parity, zero); end
  endtask
  task automatic test_random;
    logic [W-1:0] x, y;
    for (int i = 0; i < 400; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: y = x;
        1: y = ~x;
        2: x = '0;
        3: begin x = '1; y = '0; end
        default: ;
      endcase
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, x, y);
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_out_valid[%0d] got %b want %b", i, out_valid, m_valid); end
      checks++; if (result !== m_result) begin errors++; $display("FAIL rand_result[%0d] got %h want %h", i, result, m_result); end
      checks++; if (zero !== m_zero) begin errors++; $display("FAIL rand_zero[%0d] got %b want %b", i, zero, m_zero); end
      checks++; if (parity !== m_parity) begin errors++; $display("FAIL rand_parity[%0d] got %b want %b", i, parity, m_parity); end
`ifdef XOR_UNIT_POPCOUNT_EN
      checks++; if (int'(popcount) !== m_pc) begin errors++; $display("FAIL rand_popcount[%0d] got %0d want %0d", i, popcount, m_pc); end
`endif
    end
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    test_reset;
    test_complementary;
    test_identical;
    test_single_bit_hold;
    test_back_to_back;
    test_reset_during_op;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
